// File: rtl/wasm_pkg.sv
// Shared WebAssembly binary-format constants and encodings, used by both the
// module loader and the binary writer.
package wasm_pkg;

  typedef enum logic [1:0] {
    WOP_PREAMBLE = 2'd0,
    WOP_BYTE     = 2'd1,
    WOP_ULEB     = 2'd2,
    WOP_SLEB     = 2'd3
  } wasm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_EMIT     = 2'd2
  } wr_state_e;

  localparam logic [31:0] WASM_MAGIC   = 32'h0061736D;
  localparam logic [31:0] WASM_VERSION = 32'h01000000;

  // Preamble byte order is magic then version, most significant byte first.
  function automatic logic [7:0] preamble_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = WASM_MAGIC[31:24];
      3'd1:    b = WASM_MAGIC[23:16];
      3'd2:    b = WASM_MAGIC[15:8];
      3'd3:    b = WASM_MAGIC[7:0];
      3'd4:    b = WASM_VERSION[31:24];
      3'd5:    b = WASM_VERSION[23:16];
      3'd6:    b = WASM_VERSION[15:8];
      default: b = WASM_VERSION[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/leb128_step.sv
// One LEB128 encoding step: low 7 bits of v become a byte, v shifts right by 7.
// Purely combinational so it can also serve as a reference encoder.
module leb128_step (
  input  logic [31:0] v,
  input  logic        is_signed,
  output logic [7:0]  byte_out,
  output logic [31:0] v_next,
  output logic        more
);

  logic [31:0] v_lsr;
  logic [31:0] v_asr;
  logic        more_u;
  logic        more_s;

  assign v_lsr = {7'b0, v[31:7]};
  assign v_asr = {{7{v[31]}}, v[31:7]};

  assign more_u = (v_lsr != 32'd0);
  // Signed stream ends once the remainder is pure sign and bit 6 already carries it.
  assign more_s = !(((v_asr == 32'd0) && !v[6]) || ((v_asr == 32'hFFFF_FFFF) && v[6]));

  assign v_next   = is_signed ? v_asr : v_lsr;
  assign more     = is_signed ? more_s : more_u;
  assign byte_out = {more, v[6:0]};

endmodule

// File: rtl/wasm_binary_writer.sv
// Byte-serialising WebAssembly writer: preamble, raw bytes and LEB128 u32/s32,
// one addressed byte per output handshake.
module wasm_binary_writer
  import wasm_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_data,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);

  wr_state_e         state_q, state_d;
  logic [2:0]        idx_q;
  logic [31:0]       v_q;
  logic              sign_q;
  logic [7:0]        byte_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cmd_acc;
  logic              out_acc;
  logic [31:0]       step_v;
  logic              step_signed;
  logic [7:0]        step_byte;
  logic [31:0]       step_next;
  logic              step_more;

  assign cmd_acc = cmd_valid && (state_q == ST_IDLE);
  assign out_acc = out_valid && out_ready;

  // In IDLE the encoder looks at the incoming operand so the first byte is ready next cycle.
  assign step_v      = (state_q == ST_IDLE) ? cmd_data : v_q;
  assign step_signed = (state_q == ST_IDLE) ? (cmd_op == WOP_SLEB) : sign_q;

  leb128_step u_step (
    .v         (step_v),
    .is_signed (step_signed),
    .byte_out  (step_byte),
    .v_next    (step_next),
    .more      (step_more)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) state_d = (cmd_op == WOP_PREAMBLE) ? ST_PREAMBLE : ST_EMIT;
      end
      ST_PREAMBLE, ST_EMIT: begin
        if (out_acc && last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    out_valid = (state_q != ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 3'd0;
      v_q    <= 32'd0;
      sign_q <= 1'b0;
      byte_q <= 8'd0;
      last_q <= 1'b0;
      addr_q <= BASE_ADDR;
    end else if (state_q == ST_IDLE) begin
      if (addr_clr) addr_q <= BASE_ADDR;
      if (cmd_acc) begin
        case (cmd_op)
          WOP_PREAMBLE: begin
            idx_q  <= 3'd0;
            byte_q <= preamble_byte(3'd0);
            last_q <= 1'b0;
          end
          WOP_BYTE: begin
            byte_q <= cmd_data[7:0];
            last_q <= 1'b1;
          end
          default: begin
            byte_q <= step_byte;
            last_q <= !step_more;
            v_q    <= step_next;
            sign_q <= (cmd_op == WOP_SLEB);
          end
        endcase
      end
    end else if (out_acc) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (!last_q) begin
        if (state_q == ST_PREAMBLE) begin
          idx_q  <= idx_q + 3'd1;
          byte_q <= preamble_byte(idx_q + 3'd1);
          last_q <= (idx_q == 3'd6);
        end else begin
          byte_q <= step_byte;
          last_q <= !step_more;
          v_q    <= step_next;
        end
      end
    end
  end

  assign out_byte = byte_q;
  assign out_last = last_q;
  assign out_addr = addr_q;

endmodule

// File: tb/tb_wasm_binary_writer.sv
// Scoreboard bench for wasm_binary_writer: a default-width instance plus a
// 4-bit-address instance (base 14) for wrap and clear behaviour.
module tb_wasm_binary_writer;
  import wasm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        addr_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        m_cmd_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_out_byte;
  logic [11:0] m_out_addr;
  logic        s_cmd_ready, s_out_valid, s_out_last, s_busy;
  logic [7:0]  s_out_byte;
  logic [3:0]  s_out_addr;

  wasm_binary_writer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .addr_clr(addr_clr),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_byte(m_out_byte),
    .out_addr(m_out_addr), .out_last(m_out_last), .busy(m_busy)
  );

  wasm_binary_writer #(.ADDR_W(4), .BASE_ADDR(4'd14)) dut_small (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .addr_clr(addr_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_byte(s_out_byte),
    .out_addr(s_out_addr), .out_last(s_out_last), .busy(s_busy)
  );

  always #5 clk = ~clk;

  wire        o_ready = sel ? s_cmd_ready : m_cmd_ready;
  wire        o_valid = sel ? s_out_valid : m_out_valid;
  wire        o_last  = sel ? s_out_last  : m_out_last;
  wire        o_busy  = sel ? s_busy      : m_busy;
  wire [7:0]  o_byte  = sel ? s_out_byte  : m_out_byte;
  wire [11:0] o_addr  = sel ? {8'd0, s_out_addr} : m_out_addr;

  typedef struct packed {
    logic [7:0]  b;
    logic [11:0] a;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_addr = 0;

  function automatic int amask();
    return sel ? 15 : 4095;
  endfunction

  function automatic int abase();
    return sel ? 14 : 0;
  endfunction

  task automatic push_exp(input logic [7:0] b, input logic l);
    exp_t e;
    e.b = b;
    e.a = 12'(exp_addr);
    e.l = l;
    q.push_back(e);
    exp_addr = (exp_addr + 1) & amask();
  endtask

  // Bytes listed most-significant first in a 64-bit literal, n of them.
  task automatic expect_seq(input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++) push_exp(bytes[8*(n-1-i) +: 8], i == n-1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_addr = abase();
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] data, input logic clr);
    int n = 0;
    @(posedge clk); #1;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", o_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; addr_clr = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0; addr_clr = 1'b0;
    cmd_op = WOP_BYTE; cmd_data = 32'hDEAD_BEEF;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !o_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d cmd_ready=%b required pending=0 cmd_ready=1", q.size(), o_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({m_cmd_ready, m_out_valid, m_out_byte, m_out_last, m_busy, m_out_addr} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL reset_main: rdy=%b vld=%b byte=%h last=%b busy=%b addr=%h required 1 0 00 0 0 000",
               m_cmd_ready, m_out_valid, m_out_byte, m_out_last, m_busy, m_out_addr);
    end
    total++;
    if ({s_cmd_ready, s_out_valid, s_busy, s_out_addr} !== {1'b1, 1'b0, 1'b0, 4'd14}) begin
      bad++;
      $display("FAIL reset_small: rdy=%b vld=%b busy=%b addr=%0d required 1 0 0 14",
               s_cmd_ready, s_out_valid, s_busy, s_out_addr);
    end
  endtask

  task automatic test_preamble();
    sel = 1'b0; out_ready = 1'b1;
    do_reset();
    expect_seq(8, 64'h0061736D_01000000);
    send(WOP_PREAMBLE, 32'h1234_5678, 1'b0);
    total++;
    if ({o_valid, o_busy, o_ready} !== 3'b110) begin
      bad++;
      $display("FAIL preamble_start: vld=%b busy=%b rdy=%b required 1 1 0", o_valid, o_busy, o_ready);
    end
    repeat (7) @(posedge clk);
    #1;
    total++;
    if ({o_valid, o_last, o_byte} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL preamble_eighth: vld=%b last=%b byte=%h required 1 1 00", o_valid, o_last, o_byte);
    end
    @(posedge clk); #1;
    total++;
    if ({o_ready, o_valid, o_busy, q.size() == 0} !== 4'b1001) begin
      bad++;
      $display("FAIL preamble_end: rdy=%b vld=%b busy=%b pending=%0d required 1 0 0 0",
               o_ready, o_valid, o_busy, q.size());
    end
  endtask

  task automatic test_uleb();
    expect_seq(3, 64'hE58E26);      send(WOP_ULEB, 32'd624485, 1'b0);
    expect_seq(1, 64'h00);          send(WOP_ULEB, 32'd0, 1'b0);
    expect_seq(5, 64'hFFFFFFFF0F);  send(WOP_ULEB, 32'hFFFF_FFFF, 1'b0);
    expect_seq(1, 64'h7F);          send(WOP_ULEB, 32'd127, 1'b0);
    expect_seq(2, 64'h8001);        send(WOP_ULEB, 32'd128, 1'b0);
    drain();
  endtask

  task automatic test_sleb();
    expect_seq(3, 64'hC0BB78);      send(WOP_SLEB, -32'sd123456, 1'b0);
    expect_seq(1, 64'h7F);          send(WOP_SLEB, 32'hFFFF_FFFF, 1'b0);
    expect_seq(2, 64'hC000);        send(WOP_SLEB, 32'd64, 1'b0);
    expect_seq(5, 64'h8080808078);  send(WOP_SLEB, 32'h8000_0000, 1'b0);
    expect_seq(1, 64'h3F);          send(WOP_SLEB, 32'd63, 1'b0);
    expect_seq(1, 64'h40);          send(WOP_SLEB, -32'sd64, 1'b0);
    expect_seq(2, 64'hBF7F);        send(WOP_SLEB, -32'sd65, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    expect_seq(1, 64'h55); send(WOP_BYTE, 32'hFFFF_FF55, 1'b0);
    expect_seq(1, 64'h66); send(WOP_BYTE, 32'h0000_0066, 1'b0);
    expect_seq(2, 64'hAC02); send(WOP_ULEB, 32'd300, 1'b0);
    expect_seq(1, 64'h01); send(WOP_BYTE, 32'h0000_0001, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    expect_seq(2, 64'hAC02);
    send(WOP_ULEB, 32'd300, 1'b0);
    addr_clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      addr_clr = 1'b0;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_addr_wrap();
    sel = 1'b1; out_ready = 1'b1;
    do_reset();
    expect_seq(1, 64'hAA); send(WOP_BYTE, 32'h0000_00AA, 1'b0);
    expect_seq(1, 64'hBB); send(WOP_BYTE, 32'h0000_00BB, 1'b0);
    expect_seq(2, 64'hC801); send(WOP_ULEB, 32'd200, 1'b0);
    drain();
    exp_addr = abase();
    expect_seq(1, 64'h11); send(WOP_BYTE, 32'h0000_0011, 1'b1);
    drain();
    sel = 1'b0;
    @(posedge clk); #1 addr_clr = 1'b1;
    @(posedge clk); #1 addr_clr = 1'b0;
    exp_addr = abase();
    expect_seq(1, 64'h77); send(WOP_BYTE, 32'h0000_0077, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; out_ready = 1'b0;
    push_exp(8'hFF, 1'b0);
    push_exp(8'hFF, 1'b0);
    send(WOP_ULEB, 32'hFFFF_FFFF, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_valid, o_ready, o_busy, q.size() == 0} !== 4'b0101) begin
      bad++;
      $display("FAIL reset_mid_abort: vld=%b rdy=%b busy=%b pending=%0d required 0 1 0 0",
               o_valid, o_ready, o_busy, q.size());
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_addr = abase();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({o_valid, o_addr} !== {1'b0, 12'h000}) begin
      bad++;
      $display("FAIL reset_mid_quiet: vld=%b addr=%h required 0 000", o_valid, o_addr);
    end
    expect_seq(1, 64'h42); send(WOP_BYTE, 32'h0000_0042, 1'b0);
    drain();
  endtask

  initial begin
    logic       hold;
    logic [7:0] hb;
    logic [11:0] ha;
    logic       hl;
    hold = 1'b0; hb = 8'h00; ha = 12'h000; hl = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (hold) begin
            total++;
            if ({o_valid, o_byte, o_addr, o_last} !== {1'b1, hb, ha, hl}) begin
              bad++;
              $display("FAIL hold_stable: vld=%b byte=%h addr=%h last=%b required 1 %h %h %b",
                       o_valid, o_byte, o_addr, o_last, hb, ha, hl);
            end
          end
          if (o_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_byte: byte=%h addr=%h last=%b required no output", o_byte, o_addr, o_last);
            end else begin
              exp_t e;
              e = q.pop_front();
              if ({o_byte, o_addr, o_last} !== {e.b, e.a, e.l}) begin
                bad++;
                $display("FAIL sb_byte: byte=%h addr=%h last=%b required byte=%h addr=%h last=%b",
                         o_byte, o_addr, o_last, e.b, e.a, e.l);
              end
            end
          end
          hold = o_valid && !out_ready;
          hb = o_byte; ha = o_addr; hl = o_last;
        end else begin
          hold = 1'b0;
        end
      end
    join_none

    test_reset();
    test_preamble();
    test_uleb();
    test_sleb();
    test_back_to_back();
    test_backpressure();
    test_addr_wrap();
    test_reset_mid();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: pending=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wasm_binary_writer.md
Name: wasm_binary_writer

Overview:
Byte-serialising writer for the WebAssembly binary format, the emitting counterpart of the core's module loader. The loader consumes the preamble and LEB128 fields. This block produces them. It accepts encode commands (preamble, raw byte, unsigned LEB128 u32, signed LEB128 s32) and emits one byte per handshake, each with a write address. The intended sink is a byte-wide instruction/data memory or a test stream.

Parameters:
ADDR_W, 12, width of byte write address (4096-byte memory)
BASE_ADDR, 0, address assigned to the first byte after reset or addr_clr

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  writer can accept a command
cmd_op  in  2  0=PREAMBLE, 1=BYTE, 2=ULEB32, 3=SLEB32
cmd_data  in  32  operand (BYTE uses [7:0]; PREAMBLE ignores it)
addr_clr  in  1  synchronous: reload address counter to BASE_ADDR
out_valid  out  1  out_byte/out_addr valid
out_ready  in  1  sink accepts byte
out_byte  out  8  emitted byte
out_addr  out  ADDR_W  address of out_byte
out_last  out  1  final byte of the current command
busy  out  1  command in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state=IDLE. cmd_ready=1, out_valid=0, out_byte=0, out_last=0, busy=0, out_addr=BASE_ADDR, internal shift reg=0.
- Handshakes: a command is accepted on cmd_valid&&cmd_ready. A byte is accepted on out_valid&&out_ready. cmd_ready=1 only in IDLE.
- While out_valid=1 and out_ready=0, out_byte, out_addr and out_last hold stable.
- States: IDLE, PREAMBLE, EMIT.
  - IDLE, on accept: PREAMBLE op -> PREAMBLE, otherwise -> EMIT. The first byte is registered with out_valid=1 on the next cycle (latency 1).
  - PREAMBLE: emits 00 61 73 6D 01 00 00 00 in order, using a 3-bit index. out_last is set on index 7.
  - EMIT, BYTE op: a single byte cmd_data[7:0] with out_last=1.
  - EMIT, ULEB32: byte = {more, v[6:0]}. v' = v>>7 (logical). more = (v' != 0). Maximum 5 bytes.
  - EMIT, SLEB32: v' = v>>>7 (arithmetic). more = !((v'==0 && !v[6]) || (v'==all-ones && v[6])). Maximum 5 bytes.
  - out_last = !more.
- After each accepted byte: out_addr increments by 1, wrapping modulo 2^ADDR_W. The next byte is presented in the following cycle, so with out_ready held high the writer sustains 1 byte/cycle.
- On acceptance of the out_last byte: go to IDLE and drop out_valid. cmd_ready rises that same next cycle. This gives one bubble cycle between commands.
- addr_clr:
  - Honoured only in IDLE (ignored otherwise).
  - If it coincides with a command accept, the clear applies first, so the first byte of the new command goes to BASE_ADDR.
- Reset mid-command aborts immediately. The partial output is discarded, and no bytes are emitted after reset deasserts.
- cmd_data is captured at accept. Later changes have no effect.

Decomposition:
- Shared package wasm_pkg holds:
  - op encodings (WOP_PREAMBLE/BYTE/ULEB/SLEB)
  - WASM_MAGIC=32'h0061736D, WASM_VERSION=32'h01000000
  - state encodings
- The loader imports the same magic/version constants.
- One natural sub-module is leb128_step. It is combinational: (v, signed) -> (byte, v_next, more), and is reusable by the decoder testbench as a golden model.

Test Plan:
- PREAMBLE with out_ready=1, BASE_ADDR=0 -> bytes 00 61 73 6D 01 00 00 00 at addrs 0..7 on 8 consecutive cycles. out_last only on the 8th byte. cmd_ready returns the next cycle.
- ULEB32 624485 -> E5 8E 26. ULEB32 0 -> 00. ULEB32 FFFFFFFF -> FF FF FF FF 0F (5 bytes, last on 0F).
- SLEB32 -123456 -> C0 BB 78. SLEB32 -1 -> 7F. SLEB32 64 -> C0 00. SLEB32 80000000 -> 80 80 80 80 78.
- Backpressure: ULEB32 300 with out_ready toggling 0/1 every cycle -> AC 02 emitted, byte/addr held stable while ready=0, no duplicate or lost bytes.
- Address behaviour: ADDR_W=4, start addr 14, BYTE 0xAA then BYTE 0xBB -> addrs 14, 15. Next ULEB 200 -> C8 at 0, 01 at 1 (wrap). addr_clr in IDLE with a simultaneous BYTE 0x11 -> 0x11 at BASE_ADDR.
- Reset mid-ULEB32 FFFFFFFF after 2 bytes -> out_valid=0 and cmd_ready=1 immediately. A new BYTE 0x42 after release is emitted at BASE_ADDR.
